// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-clock SPI master for the SPI slave/RAM block.
//
// A host command (write addr, write data, read addr, read data) plus an
// ADDR_SIZE-bit payload is sent as one SS_n-low frame. Read-data frames
// then wait MISO_DELAY cycles and capture ADDR_SIZE MISO bits into dout.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   start  command request, accepted only while busy=0
//   cmd    00 write addr, 01 write data, 10 read addr, 11 read data
//   din    payload (address, write data, or dummy for cmd 11)
//   busy   high from the cycle after acceptance until back in idle
//   done   one-cycle pulse at the end of every completed frame
//   dout   last byte received by a cmd 11 frame
//   SS_n   slave select, active low
//   MOSI   serial data to slave
//   MISO   serial data from slave
module spi_master_ctrl #(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned MISO_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [ADDR_SIZE-1:0] din,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int unsigned TxW    = ADDR_SIZE + 2;
    localparam int unsigned CntMax = (MISO_DELAY > TxW) ? MISO_DELAY : TxW;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    // SEND spans TxW+1 cycles: the slave's select bit, then {cmd, din}.
    localparam logic [CntW-1:0] CntSend = CntW'(TxW);
    localparam logic [CntW-1:0] CntWait = (MISO_DELAY == 0) ? '0 : CntW'(MISO_DELAY - 1);
    localparam logic [CntW-1:0] CntRecv = CntW'(ADDR_SIZE - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StSend,
        StWait,
        StRecv,
        StHold,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           cmd_q, cmd_d;
    logic [TxW-1:0]       tx_q, tx_d;
    logic [ADDR_SIZE-1:0] rx_q, rx_d;
    logic [ADDR_SIZE-1:0] dout_q, dout_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        SS_n    = 1'b0;
        MOSI    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                SS_n = 1'b1;
                busy = 1'b0;
                if (start) begin
                    cmd_d   = cmd;
                    tx_d    = {cmd, din};
                    state_d = StSel;
                end
            end

            StSel: begin
                cnt_d   = CntSend;
                state_d = StSend;
            end

            StSend: begin
                MOSI = tx_q[TxW-1];
                // The first SEND cycle presents cmd[1] without shifting, so it
                // appears twice: once as the slave's select bit, once in the word.
                if (cnt_q != CntSend) begin
                    tx_d = {tx_q[TxW-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    if (cmd_q == 2'b11) begin
                        if (MISO_DELAY == 0) begin
                            cnt_d   = CntRecv;
                            state_d = StRecv;
                        end else begin
                            cnt_d   = CntWait;
                            state_d = StWait;
                        end
                    end else begin
                        state_d = StHold;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            StWait: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntRecv;
                    state_d = StRecv;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            StRecv: begin
                rx_d = {rx_q[ADDR_SIZE-2:0], MISO};
                if (cnt_q == '0) begin
                    // Load on the edge into GAP so dout is valid alongside done.
                    dout_d  = rx_d;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            StHold: begin
                state_d = StGap;
            end

            StGap: begin
                SS_n    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: self-checking bench for spi_master_ctrl.
//
// u_dut uses MISO_DELAY=2, u_dut3 uses MISO_DELAY=3; each has its own slave
// model that drives a byte on MISO in the expected window and 1s elsewhere.
// A monitor records each u_dut frame (MOSI bits while SS_n low, SS_n low
// length, done cycle, dout at done); tasks push expected frames to a queue
// when they issue a command and pop/compare once the frame is observed.
module tb_spi_master_ctrl;

    typedef struct packed {
        logic [31:0] bits;
        logic [7:0]  len;
        logic [7:0]  didx;
        logic [7:0]  dout;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start3;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       busy, done, SS_n, MOSI, MISO;
    logic [7:0] dout;
    logic       busy3, done3, SS_n3, MOSI3, MISO3;
    logic [7:0] dout3;

    int total = 0;
    int bad   = 0;

    frame_t exp_q[$];
    frame_t obs_q[$];
    frame_t exp3_q[$];
    logic [7:0] model_dout = 8'h00;
    logic [7:0] slave_byte = 8'h55;

    always #5 clk = ~clk;

    spi_master_ctrl #(.ADDR_SIZE(8), .MISO_DELAY(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cmd   (cmd),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    spi_master_ctrl #(.ADDR_SIZE(8), .MISO_DELAY(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .cmd   (cmd),
        .din   (din),
        .busy  (busy3),
        .done  (done3),
        .dout  (dout3),
        .SS_n  (SS_n3),
        .MOSI  (MOSI3),
        .MISO  (MISO3)
    );

    // Expected MOSI stream of a frame, first bit in the MSB of the low len bits.
    function automatic logic [31:0] exp_bits(input logic [1:0] c, input logic [7:0] d,
                                             input int len);
        logic [31:0] full;
        full = {1'b0, c[1], c[1], c[0], d, 20'b0};
        return full >> (32 - len);
    endfunction

    // Slave returns b MSB first in frame cycles 12+dly .. 19+dly, 1s elsewhere.
    function automatic logic slave_bit(input int fc, input int dly, input logic [7:0] b);
        int idx;
        idx = fc - 12 - dly;
        if (idx >= 0 && idx < 8) return b[7-idx];
        return 1'b1;
    endfunction

    int   fc_a = 0;
    logic ssp_a = 1'b1;
    always @(posedge clk) begin
        #1;
        if (SS_n === 1'b0) fc_a = (ssp_a === 1'b1) ? 0 : fc_a + 1;
        ssp_a = SS_n;
        MISO  = (SS_n === 1'b0) ? slave_bit(fc_a, 2, slave_byte) : 1'b1;
    end

    int   fc_b = 0;
    logic ssp_b = 1'b1;
    always @(posedge clk) begin
        #1;
        if (SS_n3 === 1'b0) fc_b = (ssp_b === 1'b1) ? 0 : fc_b + 1;
        ssp_b = SS_n3;
        MISO3 = (SS_n3 === 1'b0) ? slave_bit(fc_b, 3, slave_byte) : 1'b1;
    end

    // Frame monitor for u_dut.
    frame_t cur;
    bit     active = 1'b0;
    int     k = 0;
    int     hi_run = 0;
    int     gap_last = 0;
    int     done_cnt = 0;
    logic   mon_ss_prev = 1'b1;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (SS_n === 1'b0 && mon_ss_prev === 1'b1) begin
            active   = 1'b1;
            k        = 0;
            cur      = '0;
            cur.didx = 8'hFF;
            gap_last = hi_run;
        end
        if (SS_n === 1'b0) hi_run = 0;
        else hi_run++;
        if (active) begin
            if (SS_n === 1'b0) begin
                cur.bits = {cur.bits[30:0], MOSI};
                cur.len  = cur.len + 8'd1;
            end
            if (done === 1'b1) begin
                cur.didx = 8'(k);
                cur.dout = dout;
                obs_q.push_back(cur);
                active = 1'b0;
            end else if (rst_n === 1'b0) begin
                obs_q.push_back(cur);
                active = 1'b0;
            end
            k++;
        end
        mon_ss_prev = SS_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns in frame cycle 0 (+1).
    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        cmd   = c;
        din   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cmd   = 2'($urandom);
        din   = 8'($urandom);
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 200 && obs_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [14:0] o;
        rst_n  = 1'b0;
        start  = 1'b1;
        start3 = 1'b1;
        cmd    = 2'b11;
        din    = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = {SS_n, MOSI, busy, done, dout, SS_n3, busy3, done3};
            total++;
            if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %b required %b", i, o,
                         {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
            end
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({SS_n, busy, done, obs_q.size()} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_idle: got ss_n=%b busy=%b done=%b frames=%0d required 1 0 0 0",
                     SS_n, busy, done, obs_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_addr();
        frame_t e, o;
        int d0;
        d0 = done_cnt;
        exp_q.push_back({exp_bits(2'b00, 8'hAA, 13), 8'd13, 8'd13, model_dout});
        issue(2'b00, 8'hAA);
        wait_obs(1);
        repeat (4) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL write_addr: got no frame, required %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL write_addr: got %h required %h", o, e);
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL write_addr_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        frame_t e, o;
        exp_q.push_back({exp_bits(2'b01, 8'h55, 13), 8'd13, 8'd13, model_dout});
        exp_q.push_back({exp_bits(2'b10, 8'hAA, 13), 8'd13, 8'd13, model_dout});
        issue(2'b01, 8'h55);
        wait_obs(1);
        issue(2'b10, 8'hAA);
        wait_obs(2);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got no frame, required %h", i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL back_to_back[%0d]: got %h required %h", i, o, e);
                end
            end
        end
        total++;
        if (gap_last !== 2) begin
            bad++;
            $display("FAIL back_to_back_gap: got %0d SS_n-high cycles required 2", gap_last);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_read_data();
        frame_t e, o;
        slave_byte = 8'h55;
        model_dout = 8'h55;
        exp_q.push_back({exp_bits(2'b11, 8'h00, 22), 8'd22, 8'd22, model_dout});
        issue(2'b11, 8'h00);
        wait_obs(1);
        slave_byte = 8'hC3;
        model_dout = 8'hC3;
        exp_q.push_back({exp_bits(2'b11, 8'h5A, 22), 8'd22, 8'd22, model_dout});
        issue(2'b11, 8'h5A);
        wait_obs(2);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL read_data[%0d]: got no frame, required %h", i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL read_data[%0d]: got %h required %h", i, o, e);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_read_delay3();
        logic [23:0] e, o;
        int  len;
        bit  seen;
        len  = 0;
        seen = 1'b0;
        slave_byte = 8'h55;
        exp3_q.push_back({8'd23, 8'd23, 8'h55});
        cmd    = 2'b11;
        din    = 8'h00;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        cmd    = 2'($urandom);
        din    = 8'($urandom);
        o = {8'd0, 8'hFF, 8'h00};
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (SS_n3 === 1'b0) len++;
            if (done3 === 1'b1) begin
                seen = 1'b1;
                o    = {8'(len), 8'(i), dout3};
            end
        end
        if (!seen) o = {8'(len), 8'hFF, dout3};
        e = exp3_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL read_delay3: got len/done_at/dout=%h required %h", o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_busy();
        frame_t e, o;
        int d0;
        d0 = done_cnt;
        exp_q.push_back({exp_bits(2'b00, 8'h3C, 13), 8'd13, 8'd13, model_dout});
        issue(2'b00, 8'h3C);
        repeat (5) @(posedge clk);
        #1;
        cmd   = 2'b11;
        din   = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_obs(1);
        repeat (25) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL ignore_busy: got no frame, required %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL ignore_busy: got %h required %h", o, e);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL ignore_busy_single: got %0d done pulses, %0d extra frames required 1, 0",
                     done_cnt - d0, obs_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        frame_t e, o;
        logic [11:0] s;
        int d0;
        d0 = done_cnt;
        exp_q.push_back({exp_bits(2'b11, 8'h00, 9), 8'd9, 8'hFF, 8'h00});
        issue(2'b11, 8'h00);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        s = {SS_n, MOSI, busy, done, dout};
        total++;
        if (s !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL midframe_reset_state: got %b required %b", s,
                     {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        rst_n = 1'b1;
        model_dout = 8'h00;
        wait_obs(1);
        repeat (25) @(posedge clk);
        #1;
        total++;
        if (done_cnt !== d0) begin
            bad++;
            $display("FAIL midframe_no_done: got %0d done pulses required 0", done_cnt - d0);
        end
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL midframe_abort: got no frame, required %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL midframe_abort: got %h required %h", o, e);
            end
        end
        exp_q.push_back({exp_bits(2'b10, 8'h81, 13), 8'd13, 8'd13, model_dout});
        issue(2'b10, 8'h81);
        wait_obs(1);
        e = exp_q.pop_front();
        total++;
        if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL after_reset_frame: got no frame, required %h", e);
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL after_reset_frame: got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        start3 = 1'b0;
        test_reset();
        test_write_addr();
        test_back_to_back();
        test_read_data();
        test_read_delay3();
        test_ignore_busy();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
